// File: rtl/ifu_pkg.sv
// Shared widths, reset address, NOP encoding and the queue entry layout for the
// instruction fetch unit.
package ifu_pkg;
  localparam int PC_W    = 64;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam logic [PC_W-1:0]   RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_if.sv
// Fetch unit signal bundle: redirect from the back end, instruction memory
// request/response, and the decoded-side output queue head.
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both 1; the queue head transfers on a cycle where out_valid
// and out_ready are both 1. A valid that is up and not yet accepted keeps its
// payload stable unless a redirect intervenes. Responses have no ready and
// arrive in request order, one per accepted request.
interface ifu_if;
  import ifu_pkg::*;

  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_W-1:0]     imem_req_addr;
  logic                imem_resp_valid;
  logic [INST_W-1:0]   imem_resp_inst;
  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic [INST_W-1:0]   out_inst;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_inst, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_inst, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/ifu_queue.sv
// Synchronous instruction queue of {pc, inst} entries with flush; head is read
// straight from storage so an entry shows the cycle after it is written.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    entries_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = entries_q[rd_ptr_q];

  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush_i) entries_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited sequential fetch, in-order response
// tagging through a pc FIFO, redirect with stale-response dropping.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              QDEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  ifu_if.master    bus
);
  localparam int PW     = $clog2(QDEPTH);
  localparam int CW     = PW + 1;
  localparam int CSUM_W = CW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  // Addresses of accepted requests, popped by every response, stale or not.
  logic [PC_W-1:0] pcf_mem_q [QDEPTH];
  logic [PW-1:0]   pcf_wr_q, pcf_rd_q;

  logic            req_valid, req_fire, resp_fire, enq, deq, out_vld;
  logic [CSUM_W-1:0] credit_sum;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_wdata, q_rdata;

  assign credit_sum = {1'b0, inflight_q} + {1'b0, q_count};
  assign req_valid  = ~rst & ~bus.redirect_valid & (credit_sum < CSUM_W'(QDEPTH));
  assign req_fire   = req_valid & bus.imem_req_ready;
  assign resp_fire  = bus.imem_resp_valid;

  // Responses in a redirect cycle or while drops are pending never enter the queue.
  assign enq     = resp_fire & ~bus.redirect_valid & (drop_cnt_q == '0) & (~q_full | deq);
  assign out_vld = ~rst & ~bus.redirect_valid & ~q_empty;
  assign deq     = out_vld & bus.out_ready;

  assign q_wdata.pc   = pcf_mem_q[pcf_rd_q];
  assign q_wdata.inst = bus.imem_resp_inst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      drop_cnt_d = inflight_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (resp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= align_pc(RESET_PC);
      inflight_q <= '0;
      drop_cnt_q <= '0;
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      if (req_fire)  pcf_wr_q <= pcf_wr_q + 1'b1;
      if (resp_fire) pcf_rd_q <= pcf_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcf_mem_q[pcf_wr_q] <= fetch_pc_q;
  end

  ifu_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect_valid),
    .push_i  (enq),
    .wdata_i (q_wdata),
    .pop_i   (deq),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = out_vld;
  assign bus.out_pc         = out_vld ? q_rdata.pc : '0;
  assign bus.out_inst       = out_vld ? q_rdata.inst : '0;
endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: a small in-order memory responder plus one
// task per scenario with hand-computed expected addresses and pcs.
module tb_ifu;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_if bus ();

  ifu #(.RESET_PC(64'h0000_0000_8000_0000), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit mem_auto;
  int req_cnt;
  logic [63:0] mem_q [$];
  logic [63:0] exp_q [$];

  // Memory returns the low address word xor 0x13 as the instruction.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic step();
    logic        acc;
    logic [63:0] a;
    acc = bus.imem_req_valid & bus.imem_req_ready;
    a   = bus.imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      mem_q.push_back(a);
      req_cnt++;
    end
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    if (mem_auto && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_inst  = inst_of(a);
    end
    #1;
  endtask

  task automatic send_resp();
    logic [63:0] a;
    a = mem_q.pop_front();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_inst  = inst_of(a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = '0;
    bus.imem_req_ready  = 1'b1;
    bus.out_ready       = 1'b1;
    mem_auto = 1'b1;
    mem_q.delete();
    step();
    step();
    mem_q.delete();
    req_cnt = 0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst: got %h want 0", bus.out_inst); end
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid); end
    total++; if (bus.imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL first_req_addr: got %h want 80000000", bus.imem_req_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    step();
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0: got %b want 1", bus.out_valid); end
    total++; if (bus.out_pc !== 64'h8000_0000) begin bad++; $display("FAIL basic_pc0: got %h want 80000000", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h8000_0013) begin bad++; $display("FAIL basic_inst0: got %h want 80000013", bus.out_inst); end
    step();
    total++; if (bus.out_pc !== 64'h8000_0004) begin bad++; $display("FAIL basic_pc1: got %h want 80000004", bus.out_pc); end
    step();
    total++; if (bus.out_pc !== 64'h8000_0008) begin bad++; $display("FAIL basic_pc2: got %h want 80000008", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h8000_001b) begin bad++; $display("FAIL basic_inst2: got %h want 8000001b", bus.out_inst); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_4000;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redirect_kills_out_valid: got %b want 0", bus.out_valid); end
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    do_reset();
    bus.out_ready = 1'b0;
    repeat (10) step();
    total++; if (req_cnt !== 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", req_cnt); end
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
    exp_q.delete();
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    exp_q.push_back(64'h8000_0008);
    exp_q.push_back(64'h8000_000c);
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        total++; if (bus.out_pc !== e) begin bad++; $display("FAIL bp_drain_pc: got %h want %h", bus.out_pc, e); end
        total++; if (bus.out_inst !== inst_of(e)) begin bad++; $display("FAIL bp_drain_inst: got %h want %h", bus.out_inst, inst_of(e)); end
      end
      step();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    bit          found;
    logic [63:0] pc;
    logic [31:0] inst;
    do_reset();
    mem_auto = 1'b0;
    step(); step(); step();
    total++; if (req_cnt !== 3) begin bad++; $display("FAIL rd_inflight_reqs: got %0d want 3", req_cnt); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1003;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_req_valid_low: got %b want 0", bus.imem_req_valid); end
    step();
    total++; if (bus.imem_req_addr !== 64'h8000_1000) begin bad++; $display("FAIL rd_new_addr: got %h want 80001000", bus.imem_req_addr); end
    total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL rd_req_after: got %b want 1", bus.imem_req_valid); end
    mem_auto = 1'b1;
    found = 1'b0;
    pc = '0;
    inst = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid) begin found = 1'b1; pc = bus.out_pc; inst = bus.out_inst; end
      else step();
    end
    total++; if (!found) begin bad++; $display("FAIL rd_timeout: got none want 80001000"); end
    total++; if (pc !== 64'h8000_1000) begin bad++; $display("FAIL rd_first_pc: got %h want 80001000", pc); end
    total++; if (inst !== 32'h8000_1013) begin bad++; $display("FAIL rd_first_inst: got %h want 80001013", inst); end
  endtask

  task automatic test_redirect_same_cycle();
    bit          found;
    logic [63:0] pc;
    do_reset();
    mem_auto = 1'b0;
    step(); step();
    send_resp();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL sc_req_valid: got %b want 0", bus.imem_req_valid); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sc_out_valid: got %b want 0", bus.out_valid); end
    step();
    mem_auto = 1'b1;
    found = 1'b0;
    pc = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid) begin found = 1'b1; pc = bus.out_pc; end
      else step();
    end
    total++; if (!found) begin bad++; $display("FAIL sc_timeout: got none want 80002000"); end
    total++; if (pc !== 64'h8000_2000) begin bad++; $display("FAIL sc_first_pc: got %h want 80002000", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 64'h8000_0000) begin
        bad++; $display("FAIL stall_hold: got %b/%h want 1/80000000", bus.imem_req_valid, bus.imem_req_addr);
      end
      step();
    end
    bus.imem_req_ready = 1'b1;
    #1;
    total++; if (bus.imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL stall_release_addr: got %h want 80000000", bus.imem_req_addr); end
    step();
    total++; if (bus.imem_req_addr !== 64'h8000_0004) begin bad++; $display("FAIL stall_next_addr: got %h want 80000004", bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    step();
    total++; if (bus.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_addr_top: got %h want fffffffffffffffc", bus.imem_req_addr); end
    step();
    total++; if (bus.imem_req_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr_zero: got %h want 0", bus.imem_req_addr); end
    step();
    total++; if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_out_pc_top: got %h want fffffffffffffffc", bus.out_pc); end
    total++; if (bus.out_inst !== 32'hFFFF_FFEF) begin bad++; $display("FAIL wrap_out_inst_top: got %h want ffffffef", bus.out_inst); end
    step();
    total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL wrap_out_pc_zero: got %h want 0", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h0000_0013) begin bad++; $display("FAIL wrap_out_inst_zero: got %h want 00000013", bus.out_inst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step(); step();
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_7000;
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_req_valid: got %b want 0", bus.imem_req_valid); end
    total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0) begin bad++; $display("FAIL mid_rst_out: got %b/%h want 0/0", bus.out_valid, bus.out_pc); end
    mem_q.delete();
    step();
    rst = 1'b0;
    #1;
    total++; if (bus.imem_req_addr !== 64'h8000_0000) begin bad++; $display("FAIL mid_rst_addr: got %h want 80000000", bus.imem_req_addr); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_empty: got %b want 0", bus.out_valid); end
    step(); step();
    total++; if (bus.out_pc !== 64'h8000_0000) begin bad++; $display("FAIL mid_rst_first_pc: got %h want 80000000", bus.out_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_cnt = 0;
    mem_auto = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
